// File: rtl/conv_result_streamer.sv
// Drains conv_result after done as a k/r/c-ordered valid/ready stream; first beat 3 cycles after done.
// Sink backpressure throttles reads so buffered plus in-flight elements never exceed the 2-entry FIFO.

module fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic [W-1:0]                 din,
   input  logic                         pop,
   output logic [W-1:0]                 dout,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         empty
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH+1);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wp, rp;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (push) begin
            mem[wp] <= din;
            wp      <= nxt(wp);
         end
         if (pop) rp <= nxt(rp);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   assign dout  = mem[rp];
   assign empty = (count == '0);
endmodule

module conv_result_streamer #(
   parameter int KERNELS    = 3,
   parameter int OUT_ROWS   = 26,
   parameter int OUT_COLS   = 26,
   parameter int DATA_WIDTH = 32,
   localparam int KW = (KERNELS  > 1) ? $clog2(KERNELS)  : 1,
   localparam int RW = (OUT_ROWS > 1) ? $clog2(OUT_ROWS) : 1,
   localparam int CW = (OUT_COLS > 1) ? $clog2(OUT_COLS) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  done,
   output logic                  rd_en,
   output logic [KW-1:0]         rd_k,
   output logic [RW-1:0]         rd_r,
   output logic [CW-1:0]         rd_c,
   input  logic [DATA_WIDTH-1:0] rd_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last,
   output logic                  busy,
   output logic                  finished
);
   typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

   state_t              state, state_nxt;
   logic                issued_all;
   logic                inflight, inflight_last;
   logic                at_last, pop, head_last, empty;
   logic [1:0]          count;
   logic [2:0]          occ;
   logic [DATA_WIDTH:0] head;

   assign at_last = (rd_k == KW'(KERNELS-1)) && (rd_r == RW'(OUT_ROWS-1)) && (rd_c == CW'(OUT_COLS-1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (done) state_nxt = RUN;
         RUN:     if (pop && head_last) state_nxt = HOLD;
         HOLD:    if (!done) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Occupancy counts the beat leaving this cycle as already gone, so a full-rate stream keeps reading.
   always_comb begin
      occ      = 3'(count) + 3'(inflight) - 3'(pop);
      busy     = (state == RUN);
      rd_en    = busy && !issued_all && (occ < 3'd2);
      finished = busy && pop && head_last;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_k       <= '0;
         rd_r       <= '0;
         rd_c       <= '0;
         issued_all <= 1'b0;
      end else if (state != RUN) begin
         rd_k       <= '0;
         rd_r       <= '0;
         rd_c       <= '0;
         issued_all <= 1'b0;
      end else if (rd_en) begin
         if (at_last) issued_all <= 1'b1;
         if (rd_c == CW'(OUT_COLS-1)) begin
            rd_c <= '0;
            if (rd_r == RW'(OUT_ROWS-1)) begin
               rd_r <= '0;
               rd_k <= rd_k + 1'b1;
            end else begin
               rd_r <= rd_r + 1'b1;
            end
         end else begin
            rd_c <= rd_c + 1'b1;
         end
      end
   end

   // rd_data lands one cycle after rd_en; the last flag travels alongside it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
      end else begin
         inflight      <= rd_en;
         inflight_last <= rd_en && at_last;
      end
   end

   fifo #(.W(DATA_WIDTH+1), .DEPTH(2)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (inflight),
      .din   ({inflight_last, rd_data}),
      .pop   (pop),
      .dout  (head),
      .count (count),
      .empty (empty)
   );

   assign m_valid   = !empty;
   assign pop       = m_valid && m_ready;
   assign head_last = head[DATA_WIDTH];
   assign m_last    = m_valid && head_last;
   assign m_data    = head[DATA_WIDTH-1:0];
endmodule
